// File: rtl/ap_cmd_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ap_cmd_sequencer : bus-fed command FIFO and one-at-a-time issue FSM  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module ap_cmd_sequencer #(
  parameter int ADDR_W     = 10,
  parameter int BASE_ADDR  = 768,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 1024,
  parameter int CNT_W      = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_write,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_data,
  output logic              ap_start,
  output logic [3:0]        ap_cmd,
  output logic              ap_op_direction,
  output logic [1:0]        ap_sel_col,
  output logic [2:0]        ap_sel_internal_col,
  input  logic              ap_done,
  output logic              irq
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int TMR_W = $clog2(TIMEOUT);
  localparam int ENT_W = 10;

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_wait = 2'd1;
  localparam logic [1:0] c_st_done = 2'd2;
  localparam logic [1:0] c_st_err  = 2'd3;

  localparam logic [ADDR_W-1:0] c_base     = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] c_off_cmd  = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] c_off_ctrl = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] c_off_stat = ADDR_W'(8);
  localparam logic [ADDR_W-1:0] c_off_done = ADDR_W'(12);
  localparam logic [PTR_W:0]    c_depth    = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [TMR_W-1:0]  c_tmr_last = TMR_W'(TIMEOUT - 1);

  logic [1:0]       state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [ENT_W-1:0] mem_q [FIFO_DEPTH];
  logic [ENT_W-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [ENT_W-1:0] issued_q, issued_d;
  logic             enable_q, enable_d;
  logic             irq_en_q, irq_en_d;
  logic             irq_pending_q, irq_pending_d;
  logic             timeout_err_q, timeout_err_d;
  logic             overflow_err_q, overflow_err_d;
  logic [CNT_W-1:0] done_cnt_q, done_cnt_d;
  logic             resp_valid_q, resp_valid_d;
  logic [31:0]      resp_data_q, resp_data_d;

  logic [ADDR_W-1:0] w_offset;
  logic              w_wr_cmd, w_wr_ctrl, w_wr_stat, w_rd;
  logic [ENT_W-1:0]  w_head, w_entry;
  logic              w_issue, w_done_evt, w_err_evt, w_busy;
  logic              w_push_ok, w_flush;
  logic [31:0]       w_rd_data;
  logic              unused_wdata;

  assign unused_wdata = ^{req_wdata[31:27], req_wdata[23:18], req_wdata[15:9], req_wdata[7:4]};

  // Offset wraps modulo 2^ADDR_W, so addresses below the base never alias a register.
  always_comb begin
    w_offset  = req_addr - c_base;
    w_wr_cmd  = req_valid && req_write && (w_offset == c_off_cmd);
    w_wr_ctrl = req_valid && req_write && (w_offset == c_off_ctrl);
    w_wr_stat = req_valid && req_write && (w_offset == c_off_stat);
    w_rd      = req_valid && !req_write;
    w_entry   = {req_wdata[26:24], req_wdata[17:16], req_wdata[8], req_wdata[3:0]};
    w_head    = mem_q[rd_ptr_q];
  end

  // FSM: state register
  always_ff @(posedge clock) begin
    if (reset) state_q <= c_st_idle;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_st_idle: if (w_issue) state_d = c_st_wait;
      c_st_wait: begin
        if (ap_done)                   state_d = c_st_done;
        else if (timer_q == c_tmr_last) state_d = c_st_err;
      end
      c_st_done: state_d = c_st_idle;
      c_st_err:  state_d = c_st_idle;
      default:   state_d = c_st_idle;
    endcase
  end

  // FSM: outputs. The head entry is driven straight onto ap_* in the issue cycle.
  always_comb begin
    w_issue    = (state_q == c_st_idle) && enable_q && (count_q != '0);
    w_done_evt = (state_q == c_st_done);
    w_err_evt  = (state_q == c_st_err);
    w_busy     = (state_q != c_st_idle);
    ap_start   = w_issue;
    {ap_sel_internal_col, ap_sel_col, ap_op_direction, ap_cmd} = w_issue ? w_head : issued_q;
  end

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  always_comb begin
    w_push_ok = w_wr_cmd && ((count_q != c_depth) || w_issue);
    w_flush   = (w_wr_ctrl && req_wdata[1]) || w_err_evt;
    mem_d     = mem_q;
    if (w_push_ok) mem_d[wr_ptr_q] = w_entry;
    wr_ptr_d = wr_ptr_q + PTR_W'(w_push_ok);
    rd_ptr_d = rd_ptr_q + PTR_W'(w_issue);
    count_d  = count_q + (PTR_W+1)'(w_push_ok) - (PTR_W+1)'(w_issue);
    if (w_flush) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = (PTR_W+1)'(w_push_ok);
    end
  end

  always_comb begin
    timer_d  = ((state_q == c_st_wait) && (state_d == c_st_wait)) ? timer_q + 1'b1 : '0;
    issued_d = w_issue ? w_head : issued_q;

    enable_d = enable_q;
    irq_en_d = irq_en_q;
    if (w_wr_ctrl) begin
      enable_d = req_wdata[0];
      irq_en_d = req_wdata[8];
    end

    // Write-one-to-clear first so a same-cycle hardware set takes precedence.
    irq_pending_d  = irq_pending_q  && !(w_wr_stat && req_wdata[0]);
    timeout_err_d  = timeout_err_q  && !(w_wr_stat && req_wdata[2]);
    overflow_err_d = overflow_err_q && !(w_wr_stat && req_wdata[3]);
    if (w_done_evt || w_err_evt) irq_pending_d  = 1'b1;
    if (w_err_evt)               timeout_err_d  = 1'b1;
    if (w_wr_cmd && !w_push_ok)  overflow_err_d = 1'b1;

    done_cnt_d = done_cnt_q + CNT_W'(w_done_evt);
  end

  always_comb begin
    w_rd_data = 32'd0;
    case (w_offset)
      c_off_ctrl: w_rd_data = {23'd0, irq_en_q, 7'd0, enable_q};
      c_off_stat: w_rd_data = {16'd0, 8'(count_q), 4'd0, overflow_err_q, timeout_err_q,
                               w_busy, irq_pending_q};
      c_off_done: w_rd_data = 32'(done_cnt_q);
      default:    w_rd_data = 32'd0;
    endcase
    resp_valid_d = w_rd;
    resp_data_d  = w_rd ? w_rd_data : 32'd0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      timer_q        <= '0;
      mem_q          <= '{default: '0};
      rd_ptr_q       <= '0;
      wr_ptr_q       <= '0;
      count_q        <= '0;
      issued_q       <= '0;
      enable_q       <= 1'b0;
      irq_en_q       <= 1'b0;
      irq_pending_q  <= 1'b0;
      timeout_err_q  <= 1'b0;
      overflow_err_q <= 1'b0;
      done_cnt_q     <= '0;
      resp_valid_q   <= 1'b0;
      resp_data_q    <= 32'd0;
    end else begin
      timer_q        <= timer_d;
      mem_q          <= mem_d;
      rd_ptr_q       <= rd_ptr_d;
      wr_ptr_q       <= wr_ptr_d;
      count_q        <= count_d;
      issued_q       <= issued_d;
      enable_q       <= enable_d;
      irq_en_q       <= irq_en_d;
      irq_pending_q  <= irq_pending_d;
      timeout_err_q  <= timeout_err_d;
      overflow_err_q <= overflow_err_d;
      done_cnt_q     <= done_cnt_d;
      resp_valid_q   <= resp_valid_d;
      resp_data_q    <= resp_data_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign irq        = irq_pending_q & irq_en_q;

endmodule
`default_nettype wire

// File: tb/tb_ap_cmd_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ap_cmd_sequencer : random + directed bench with queue scoreboard  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_ap_cmd_sequencer;

  localparam int ADDR_W = 10;
  localparam int BASE   = 768;
  localparam int DEPTH  = 4;
  localparam int TMO    = 16;
  localparam int CNT_W  = 4;

  logic        clock = 1'b0;
  logic        reset, req_valid, req_write, ap_done;
  logic [9:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid, ap_start, ap_op_direction, irq;
  logic [31:0] resp_data;
  logic [3:0]  ap_cmd;
  logic [1:0]  ap_sel_col;
  logic [2:0]  ap_sel_internal_col;

  always #5 clock = ~clock;

  ap_cmd_sequencer #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH),
                     .TIMEOUT(TMO), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_write(req_write), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_data(resp_data), .ap_start(ap_start), .ap_cmd(ap_cmd),
    .ap_op_direction(ap_op_direction), .ap_sel_col(ap_sel_col),
    .ap_sel_internal_col(ap_sel_internal_col), .ap_done(ap_done), .irq(irq)
  );

  typedef struct { int cyc; logic [31:0] val; } exp_t;
  exp_t start_q[$];
  exp_t resp_q[$];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Reference model: command queue plus "waiting since N cycles" and "wrap-up pending" notions.
  logic [9:0] mq[$];
  int   m_wait;      // -1: no command outstanding, else cycles spent waiting
  int   m_fin;       // 0 none, 1 completion wrap-up next, 2 timeout wrap-up next
  bit   m_en, m_ie, m_irqp, m_terr, m_ovf;
  int   m_cnt;
  logic [9:0] m_held;

  bit         e_valid = 1'b0;
  bit         e_start, e_irq;
  logic [9:0] e_fields;
  int         done_mode = 0;
  int         done_dly  = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(string name, int seen, int want);
    vectors++;
    miscompares++;
    $display("FAIL %s: seen at cycle %0d, expected at cycle %0d", name, seen, want);
  endtask

  function automatic logic [9:0] enc(logic [31:0] w);
    return {w[26:24], w[17:16], w[8], w[3:0]};
  endfunction

  function automatic void model_reset();
    mq.delete();
    m_wait = -1; m_fin = 0; m_cnt = 0; m_held = '0;
    m_en = 0; m_ie = 0; m_irqp = 0; m_terr = 0; m_ovf = 0;
  endfunction

  function automatic logic [31:0] model_read(int off);
    logic [31:0] v;
    bit busy;
    busy = (m_wait >= 0) || (m_fin != 0);
    case (off)
      4:  v = (32'(m_ie) << 8) | 32'(m_en);
      8:  v = (32'(mq.size()) << 8) | (32'(m_ovf) << 3) | (32'(m_terr) << 2) |
              (32'(busy) << 1) | 32'(m_irqp);
      12: v = 32'(m_cnt % (1 << CNT_W));
      default: v = 32'd0;
    endcase
    return v;
  endfunction

  function automatic void model_step(bit rst, bit rv, bit rw, int off, logic [31:0] wd, bit dn);
    bit issue, flush, acc, wcmd, wctrl, wstat;
    int sz, nf;
    logic [9:0] popped;
    issue    = (m_wait < 0) && (m_fin == 0) && m_en && (mq.size() > 0);
    e_start  = issue;
    e_fields = issue ? mq[0] : m_held;
    e_irq    = m_irqp & m_ie;
    e_valid  = 1'b1;
    if (issue) start_q.push_back('{cyc, 32'(mq[0])});
    if (rst) begin
      model_reset();
      return;
    end
    if (rv && !rw) resp_q.push_back('{cyc + 1, model_read(off)});
    wcmd  = rv && rw && (off == 0);
    wctrl = rv && rw && (off == 4);
    wstat = rv && rw && (off == 8);
    sz    = mq.size();
    popped = '0;
    if (issue) popped = mq.pop_front();
    flush = (wctrl && wd[1]) || (m_fin == 2);
    acc   = wcmd && ((sz < DEPTH) || issue);
    if (flush) mq.delete();
    if (acc) mq.push_back(enc(wd));
    else if (wcmd) m_ovf = 1;
    if (wstat) begin
      if (wd[0]) m_irqp = 0;
      if (wd[2]) m_terr = 0;
      if (wd[3]) m_ovf  = 0;
    end
    if (m_fin == 1) begin m_cnt++;    m_irqp = 1; end
    if (m_fin == 2) begin m_terr = 1; m_irqp = 1; end
    if (wctrl) begin m_en = wd[0]; m_ie = wd[8]; end
    nf = 0;
    if (issue) begin
      m_held = popped;
      m_wait = 0;
    end else if (m_wait >= 0) begin
      if (dn)                     begin nf = 1; m_wait = -1; end
      else if (m_wait == TMO - 1) begin nf = 2; m_wait = -1; end
      else m_wait++;
    end
    m_fin = nf;
  endfunction

  task automatic cycle(bit rst, bit rv, bit rw, int off, logic [31:0] wd);
    bit dn;
    @(posedge clock);
    #1;
    case (done_mode)
      0:       dn = 1'b0;
      1:       dn = (m_wait == done_dly);
      3:       dn = 1'b1;
      default: dn = ($urandom_range(5) == 0);
    endcase
    reset     = rst;
    req_valid = rv;
    req_write = rw;
    req_addr  = 10'(BASE + off);
    req_wdata = wd;
    ap_done   = dn;
    model_step(rst, rv, rw, off, wd, dn);
  endtask

  task automatic idle(int n);
    repeat (n) cycle(0, 0, 0, 0, 32'd0);
  endtask
  task automatic wr(int off, logic [31:0] d);
    cycle(0, 1, 1, off, d);
  endtask
  task automatic rd(int off);
    cycle(0, 1, 0, off, 32'd0);
  endtask
  task automatic wait_quiet(int budget);
    for (int i = 0; i < budget && !(m_wait < 0 && m_fin == 0 && mq.size() == 0); i++) idle(1);
  endtask

  // Monitor: per-cycle output levels plus event scoreboards for starts and read responses.
  always @(negedge clock) begin
    exp_t e;
    if (e_valid) begin
      check("ap_start", 32'(ap_start), 32'(e_start));
      check("ap_fields", {22'd0, ap_sel_internal_col, ap_sel_col, ap_op_direction, ap_cmd},
            32'(e_fields));
      check("irq", 32'(irq), 32'(e_irq));
      if (ap_start) begin
        if (start_q.size() == 0) flag("start_unexpected", cyc, -1);
        else begin
          e = start_q.pop_front();
          check("start_cycle", cyc, e.cyc);
          check("start_fields", {22'd0, ap_sel_internal_col, ap_sel_col, ap_op_direction, ap_cmd},
                e.val);
        end
      end
      while (start_q.size() > 0 && start_q[0].cyc < cyc) begin
        e = start_q.pop_front();
        flag("start_missed", -1, e.cyc);
      end
      if (resp_valid) begin
        if (resp_q.size() == 0 || resp_q[0].cyc != cyc) flag("resp_unexpected", cyc, -1);
        else begin
          e = resp_q.pop_front();
          check("resp_data", resp_data, e.val);
        end
      end
      while (resp_q.size() > 0 && resp_q[0].cyc <= cyc) begin
        e = resp_q.pop_front();
        flag("resp_missed", -1, e.cyc);
      end
    end
  end

  initial begin
    int r, off;
    int offs[7] = '{0, 4, 8, 12, 16, -4, 32};
    logic [31:0] d;
    reset = 1; req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0; ap_done = 0;
    model_reset();
    cycle(1, 0, 0, 0, 32'd0);
    cycle(1, 0, 0, 0, 32'd0);
    idle(1);
    rd(8); rd(12); rd(4);

    // Single command, done five cycles after start
    done_mode = 1; done_dly = 5;
    wr(0, 32'h0402_0103);
    wr(4, 32'h0000_0101);
    idle(10);
    rd(12); rd(8);

    // Fill while disabled, overflow on the fifth, then drain in order
    wr(4, 32'h0); wr(8, 32'hD);
    for (int i = 0; i < 5; i++) wr(0, $urandom);
    rd(8);
    done_dly = 3;
    wr(4, 32'h1);
    wait_quiet(60);
    rd(8); rd(12);

    // Timeout with irq disabled, then irq enabled
    done_mode = 0;
    wr(8, 32'hF);
    for (int i = 0; i < 3; i++) wr(0, $urandom);
    wr(4, 32'h1);
    wait_quiet(TMO + 10);
    rd(8);
    wr(4, 32'h101);
    idle(2);

    // Clear irq_pending + timeout_err in the same cycle completion sets irq_pending
    done_mode = 1; done_dly = 2;
    wr(0, $urandom);
    for (int i = 0; i < 64 && m_fin != 1; i++) idle(1);
    wr(8, 32'h5);
    rd(8); rd(12);

    // Reset while waiting; late ap_done afterwards
    done_mode = 0;
    wr(0, $urandom);
    for (int i = 0; i < 64 && m_wait < 3; i++) idle(1);
    cycle(1, 0, 0, 0, 32'd0);
    done_mode = 3;
    idle(3);
    rd(8); rd(12); rd(4);

    // Unmapped reads and done-counter wrap
    rd(16); rd(-4); rd(32);
    done_mode = 1; done_dly = 1;
    wr(4, 32'h1);
    for (int i = 0; i < (1 << CNT_W) + 1; i++) begin
      wr(0, $urandom);
      wait_quiet(40);
    end
    rd(12);

    // Random traffic
    done_mode = 2;
    for (int n = 0; n < 4000; n++) begin
      r = $urandom_range(99);
      if (r < 45) idle(1);
      else if (r < 65) wr(0, $urandom);
      else if (r < 72) begin
        d = 32'($urandom_range(3) != 0) | (32'($urandom_range(7) == 0) << 1) |
            (32'($urandom_range(1)) << 8);
        wr(4, d);
      end
      else if (r < 78) wr(8, 32'($urandom_range(15)));
      else if (r < 80) wr(16, $urandom);
      else if (r < 97) begin
        off = offs[$urandom_range(6)];
        rd(off);
      end
      else if (r < 98) cycle(1, 0, 0, 0, 32'd0);
      else begin
        done_mode = (done_mode == 2) ? 0 : 2;
        idle(1);
      end
    end

    done_mode = 1; done_dly = 2;
    wr(4, 32'h101);
    wait_quiet(200);
    rd(8); rd(12);
    idle(4);
    vectors++;
    if (start_q.size() != 0 || resp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d starts and %0d responses outstanding, expected 0 and 0",
               start_q.size(), resp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
